// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state codes and per-state output decode for the alarm controller
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    typedef struct packed {
        logic a;
        logic l;
        logic beep;
    } outs_t;

    function automatic outs_t outs_of(state_t s);
        outs_t o;
        o.a    = (s == ARMED) || (s == ENTRY) || (s == ALARM);
        o.l    = (s == ALARM);
        o.beep = (s == EXIT) || (s == ENTRY);
        return o;
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// alarm_timer: loadable down-counter that holds at zero and flags expiry
module alarm_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: five-state Moore alarm FSM with one shared exit/entry/siren timer
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int EXIT_CYC  = 8,
    parameter int ENTRY_CYC = 8,
    parameter int SIREN_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       disarm,
    input  logic       V,
    input  logic       M,
    output logic       A,
    output logic       L,
    output logic       beep,
    output logic [2:0] state
);

    localparam int MAX_CYC = (EXIT_CYC > ENTRY_CYC)
                           ? ((EXIT_CYC > SIREN_CYC) ? EXIT_CYC : SIREN_CYC)
                           : ((ENTRY_CYC > SIREN_CYC) ? ENTRY_CYC : SIREN_CYC);
    localparam int TW = $clog2(MAX_CYC) + 1;

    state_t        state_q, state_d;
    logic          load, expired;
    logic [TW-1:0] load_val;
    outs_t         outs_d;

    alarm_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .value   (load_val),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        if (disarm) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: if (arm) begin
                    state_d  = EXIT;
                    load     = 1'b1;
                    load_val = TW'(EXIT_CYC - 1);
                end
                EXIT: if (expired) state_d = ARMED;
                ARMED: if (A & M) begin
                    state_d  = ALARM;
                    load     = 1'b1;
                    load_val = TW'(SIREN_CYC - 1);
                end else if (A & ~V) begin
                    state_d  = ENTRY;
                    load     = 1'b1;
                    load_val = TW'(ENTRY_CYC - 1);
                end
                ENTRY: if (expired) begin
                    state_d  = ALARM;
                    load     = 1'b1;
                    load_val = TW'(SIREN_CYC - 1);
                end
                ALARM: if (expired) begin
                    state_d  = (V & ~M) ? ARMED : ALARM;
                    load     = ~(V & ~M);
                    load_val = TW'(SIREN_CYC - 1);
                end
                default: state_d = DISARMED;
            endcase
        end
        outs_d = outs_of(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISARMED;
            A       <= 1'b0;
            L       <= 1'b0;
            beep    <= 1'b0;
        end else begin
            state_q <= state_d;
            A       <= outs_d.a;
            L       <= outs_d.l;
            beep    <= outs_d.beep;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed and random stimulus checked against a deadline-based reference model
module tb_alarm_ctrl;

    localparam int EXIT_CYC  = 8;
    localparam int ENTRY_CYC = 8;
    localparam int SIREN_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0, disarm = 1'b0, V = 1'b1, M = 1'b0;
    logic       A, L, beep;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int ms = 0;
    int deadline = 0;

    alarm_ctrl #(.EXIT_CYC(EXIT_CYC), .ENTRY_CYC(ENTRY_CYC), .SIREN_CYC(SIREN_CYC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arm    (arm),
        .disarm (disarm),
        .V      (V),
        .M      (M),
        .A      (A),
        .L      (L),
        .beep   (beep),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, int'(state), ms);
        check({tag, ".A"},     int'(A),     int'(ms == 2 || ms == 3 || ms == 4));
        check({tag, ".L"},     int'(L),     int'(ms == 4));
        check({tag, ".beep"},  int'(beep),  int'(ms == 1 || ms == 3));
    endtask

    // Model: each timed state transitions exactly at a recorded deadline edge.
    task automatic model_edge();
        edge_n++;
        if (disarm) ms = 0;
        else case (ms)
            0: if (arm) begin ms = 1; deadline = edge_n + EXIT_CYC; end
            1: if (edge_n == deadline) ms = 2;
            2: if (M) begin ms = 4; deadline = edge_n + SIREN_CYC; end
               else if (!V) begin ms = 3; deadline = edge_n + ENTRY_CYC; end
            3: if (edge_n == deadline) begin ms = 4; deadline = edge_n + SIREN_CYC; end
            4: if (edge_n == deadline) begin
                   if (V && !M) ms = 2;
                   else deadline = edge_n + SIREN_CYC;
               end
            default: ms = 0;
        endcase
    endtask

    task automatic step(input logic a_i, input logic d_i, input logic v_i, input logic m_i, input string tag);
        arm = a_i; disarm = d_i; V = v_i; M = m_i;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic steps(input int n, input logic v_i, input logic m_i, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, v_i, m_i, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        ms = 0;
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_edge();
        check_all("idle");

        step(1'b1, 1'b0, 1'b1, 1'b0, "arm");
        check("arm_beep", int'(beep), 1);
        steps(EXIT_CYC - 1, 1'b0, 1'b1, "exit_hold");
        check("exit_still", int'(state), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "exit_done");
        check("armed_A", int'(A), 1);

        step(1'b0, 1'b0, 1'b0, 1'b0, "door_open");
        check("entry_state", int'(state), 3);
        steps(ENTRY_CYC, 1'b1, 1'b0, "entry");
        check("entry_to_alarm", int'(state), 4);
        steps(SIREN_CYC - 1, 1'b1, 1'b0, "siren");
        check("siren_held", int'(L), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "siren_end");
        check("back_armed", int'(state), 2);

        step(1'b0, 1'b0, 1'b0, 1'b1, "motion_door");
        check("direct_alarm", int'(state), 4);
        steps(SIREN_CYC - 1, 1'b1, 1'b0, "siren2");
        step(1'b0, 1'b0, 1'b1, 1'b1, "expire_motion");
        check("stay_alarm", int'(state), 4);
        steps(SIREN_CYC, 1'b1, 1'b0, "siren3");
        check("rearmed", int'(state), 2);

        step(1'b0, 1'b1, 1'b1, 1'b0, "disarm");
        step(1'b1, 1'b1, 1'b1, 1'b0, "arm_disarm");
        check("arm_disarm_state", int'(state), 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, "arm2");
        steps(EXIT_CYC, 1'b0, 1'b1, "exit2");
        step(1'b0, 1'b0, 1'b0, 1'b0, "entry2");
        steps(4, 1'b1, 1'b0, "entry2_wait");
        step(1'b0, 1'b1, 1'b1, 1'b0, "entry_disarm");
        check("entry_disarm_A", int'(A), 0);

        step(1'b1, 1'b0, 1'b1, 1'b0, "arm3");
        steps(EXIT_CYC, 1'b1, 1'b0, "exit3");
        step(1'b0, 1'b0, 1'b1, 1'b1, "motion");
        steps(3, 1'b1, 1'b0, "alarm3");
        async_reset("mid_alarm_reset");
        steps(3, 1'b0, 1'b1, "post_reset");
        check("needs_rearm", int'(state), 0);

        step(1'b1, 1'b0, 1'b1, 1'b0, "arm4");
        steps(3, 1'b1, 1'b0, "exit4");
        async_reset("mid_exit_reset");
        steps(EXIT_CYC + 2, 1'b1, 1'b0, "post_reset2");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset("rand_reset");
            step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 14) != 0, $urandom_range(0, 24) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter EXIT_CYC, default 8: cycles from arming request to armed state (must be >= 1).
REQ-002 Parameter ENTRY_CYC, default 8: grace cycles after a door/window opening before alarm (must be >= 1).
REQ-003 Parameter SIREN_CYC, default 16: cycles L stays asserted per alarm episode (must be >= 1).
REQ-004 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port arm  input  1  arming request, level-sampled each rising edge.
REQ-007 Port disarm  input  1  disarm request, level-sampled each rising edge.
REQ-008 Port V  input  1  window/door sensor, 1 = closed/OK.
REQ-009 Port M  input  1  motion sensor, 1 = motion detected.
REQ-010 Port A  output  1  system armed (1 in ARMED, ENTRY, ALARM).
REQ-011 Port L  output  1  siren and lights on.
REQ-012 Port beep  output  1  warning tone, 1 in EXIT and ENTRY.
REQ-013 Port state  output  3  current state code.

Function
REQ-014 The block SHALL be a five-state Moore FSM: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 SHALL recover to DISARMED on the next edge.
REQ-015 All outputs SHALL be registered and SHALL reflect the state entered at the most recent rising edge (one-cycle input-to-output latency).
REQ-016 disarm=1 SHALL move any state to DISARMED on the next edge, with priority over arm, sensors and timer expiry.
REQ-017 DISARMED: arm=1 and disarm=0 SHALL enter EXIT and load the timer; arm in any other state SHALL be ignored.
REQ-018 EXIT: V and M SHALL be ignored; entering EXIT at edge t SHALL yield ARMED at edge t+EXIT_CYC.
REQ-019 ARMED: M=1 SHALL enter ALARM; else V=0 SHALL enter ENTRY; M=1 with V=0 together SHALL enter ALARM (motion priority).
REQ-020 ENTRY: M and V SHALL be ignored; entering ENTRY at edge t SHALL yield ALARM at edge t+ENTRY_CYC unless disarmed.
REQ-021 ALARM: L=1 for SIREN_CYC cycles; on expiry, if V=1 and M=0 the FSM SHALL return to ARMED, otherwise it SHALL reload the timer and remain in ALARM.
REQ-022 The armed-state alarm decision SHALL equal A&~V | A&M evaluated with registered A.
REQ-023 One shared down-counter SHALL serve all timed states, sized $clog2 of the largest parameter plus 1; it SHALL load N-1 on state entry and expire at 0, never wrapping.
REQ-024 Outputs per state: DISARMED A=0 L=0 beep=0; EXIT A=0 L=0 beep=1; ARMED A=1 L=0 beep=0; ENTRY A=1 L=0 beep=1; ALARM A=1 L=1 beep=0.

Reset
REQ-025 rst_n=0 SHALL immediately force state=DISARMED, timer=0, A=0, L=0, beep=0, independent of clk.
REQ-026 Reset asserted mid-EXIT, mid-ENTRY or mid-ALARM SHALL abort the timing; after release the FSM SHALL require a new arm request.

Structure
REQ-027 State codes and the 3-bit state type SHALL live in shared package alarm_pkg.
REQ-028 The timer SHALL be a sub-module alarm_timer (load, value, expired flag) instantiated once.

Verification
REQ-029 Reset then arm=1 for 1 cycle -> state=1, beep=1 next edge; state=2, A=1 exactly 8 edges later.
REQ-030 ARMED, V=0 one cycle -> ENTRY, beep=1; no disarm -> state=4, L=1 8 edges later; L held 16 cycles.
REQ-031 ARMED, V=0 and M=1 same cycle -> state=4 next edge (no ENTRY).
REQ-032 ALARM with V=1, M=0 at expiry -> state=2, L=0; with M=1 at expiry -> remains state=4 for another 16 cycles.
REQ-033 arm=1 and disarm=1 together in DISARMED -> stays state=0; disarm in ENTRY cycle 5 -> state=0, A=0.
REQ-034 rst_n pulsed low mid-ALARM between clock edges -> L=0, state=0 immediately, before the next edge.
